obj_line_buffer_pp: RTL and testbench



---
 rtl/obj_line_buffer_pp.sv | 98 +++++++++
 tb/tb_obj_line_buffer_pp.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/obj_line_buffer_pp.sv
// Ping-pong sprite line buffer: the sprite engine fills one bank while the video side reads the other.
// Optional OBJ_LB_CLEAR_ON_READ_EN: each accepted read also writes TRANSP back, leaving a scanned bank clean.
module obj_line_buffer_pp #(
  parameter int                 DATA_W = 8,
  parameter int                 ADDR_W = 9,
  parameter logic [DATA_W-1:0]  TRANSP = {DATA_W{1'b1}}
) (
  input  logic              clk,
  input  logic              RESETn,
  input  logic              swap,
  input  logic              wr_load,
  input  logic [ADDR_W-1:0] wr_x,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_load,
  input  logic [ADDR_W-1:0] rd_x,
  input  logic              rd_dir,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_bank
);

  localparam int                DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);

  logic [DATA_W-1:0] mem [2*DEPTH];
  logic [ADDR_W-1:0] wa, ra;
  logic [ADDR_W-1:0] wa_cur, ra_cur;
  logic              wr_hit;
  logic              rd_bank;

  // A load in the same cycle as an access makes the loaded X the access address.
  // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
  always_comb begin
    wa_cur  = wr_load ? wr_x : wa;
    ra_cur  = rd_load ? rd_x : ra;
    wr_hit  = wr_en && (wr_data != TRANSP);
    rd_bank = ~wr_bank;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      wr_bank <= 1'b0;
    end else if (swap) begin
      wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      wa <= '0;
    end else if (wr_en) begin
      wa <= wa_cur + ONE;
    end else if (wr_load) begin
      wa <= wr_x;
    end
  end

  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      ra <= '0;
    end else if (rd_en) begin
      ra <= rd_dir ? (ra_cur + ONE) : (ra_cur - ONE);
    end else if (rd_load) begin
      ra <= rd_x;
    end
  end

  // NOTE: the RAM has no reset so it maps onto block RAM; only counters and outputs reset.
  // Write and read banks always differ, so the two write ports never hit the same entry.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[{wr_bank, wa_cur}] <= wr_data;
    end
`ifdef OBJ_LB_CLEAR_ON_READ_EN
    if (rd_en) begin
      mem[{rd_bank, ra_cur}] <= TRANSP;
    end
`else
`endif
  end

  // Registered read port; the non-blocking update gives old data when the clear port fires too.
  always_ff @(posedge clk or negedge RESETn) begin
    if (!RESETn) begin
      rd_data  <= TRANSP;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= mem[{rd_bank, ra_cur}];
      end
    end
  end

endmodule

// File: tb/tb_obj_line_buffer_pp.sv
// Directed bench for obj_line_buffer_pp at default parameters; expectations are hand-computed.
module tb_obj_line_buffer_pp;

  logic       clk = 1'b0;
  logic       RESETn;
  logic       swap, wr_load, wr_en, rd_load, rd_dir, rd_en;
  logic [8:0] wr_x, rd_x;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       wr_bank;

  int n_assert = 0;
  int n_fail   = 0;

`ifdef OBJ_LB_CLEAR_ON_READ_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  obj_line_buffer_pp dut (
    .clk      (clk),
    .RESETn   (RESETn),
    .swap     (swap),
    .wr_load  (wr_load),
    .wr_x     (wr_x),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_load  (rd_load),
    .rd_x     (rd_x),
    .rd_dir   (rd_dir),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .wr_bank  (wr_bank)
  );

  always #5 clk = ~clk;

  // A location already read once comes back as TRANSP when clear-on-read is built in.
  function automatic logic [7:0] reread(input logic [7:0] v);
    return CLR ? 8'hFF : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rd(input string tag, input logic [7:0] exp);
    chk({tag, "_valid"}, 32'(rd_valid), 32'd1);
    chk({tag, "_data"}, 32'(rd_data), 32'(exp));
  endtask

  task automatic idle();
    swap = 0; wr_load = 0; wr_en = 0; rd_load = 0; rd_en = 0;
  endtask

  // Inputs change at the falling edge; outputs are sampled at the following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input bit load, input logic [8:0] x, input logic [7:0] d);
    idle(); wr_load = load; wr_x = x; wr_en = 1; wr_data = d; step();
  endtask

  task automatic rd(input bit load, input logic [8:0] x, input bit dir);
    idle(); rd_load = load; rd_x = x; rd_dir = dir; rd_en = 1; step();
  endtask

  task automatic do_swap();
    idle(); swap = 1; step();
  endtask

  initial begin
    idle();
    RESETn = 0; wr_x = '0; rd_x = '0; rd_dir = 1; wr_data = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_rd_data", 32'(rd_data), 32'hFF);
    chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    chk("rst_wr_bank", 32'(wr_bank), 32'd0);
    RESETn = 1;
    step();
    chk("idle_rd_data", 32'(rd_data), 32'hFF);

    // Bank 0: @12 = 0x77, then load 10 and write 12,34,FF(skip),56
    wr(1, 9'd12, 8'h77);
    idle(); wr_load = 1; wr_x = 9'd10; step();
    wr(0, 9'd0, 8'h12);
    wr(0, 9'd0, 8'h34);
    wr(0, 9'd0, 8'hFF);
    wr(0, 9'd0, 8'h56);
    do_swap();
    chk("swap1_wr_bank", 32'(wr_bank), 32'd1);

    // Forward read with load+en in the first cycle
    rd(1, 9'd10, 1); chk_rd("fwd0", 8'h12);
    rd(0, 9'd0, 1);  chk_rd("fwd1", 8'h34);
    rd(0, 9'd0, 1);  chk_rd("fwd2", 8'h77);
    rd(0, 9'd0, 1);  chk_rd("fwd3", 8'h56);
    idle(); step();
    chk("hold_valid", 32'(rd_valid), 32'd0);
    chk("hold_data", 32'(rd_data), 32'h56);

    // Reverse read (screen flip)
    rd(1, 9'd13, 0); chk_rd("rev0", reread(8'h56));
    rd(0, 9'd0, 0);  chk_rd("rev1", reread(8'h77));
    rd(0, 9'd0, 0);  chk_rd("rev2", reread(8'h34));
    rd(0, 9'd0, 0);  chk_rd("rev3", reread(8'h12));

    // Wrap: bank 1 @511 = A0, @0 = A1
    wr(1, 9'd511, 8'hA0);
    wr(0, 9'd0, 8'hA1);
    do_swap();
    chk("swap2_wr_bank", 32'(wr_bank), 32'd0);
    idle(); rd_load = 1; rd_x = 9'd511; rd_dir = 1; step();
    chk("load_only_valid", 32'(rd_valid), 32'd0);
    rd(0, 9'd0, 1); chk_rd("wrap_up0", 8'hA0);
    rd(0, 9'd0, 1); chk_rd("wrap_up1", 8'hA1);
    rd(1, 9'd0, 0); chk_rd("wrap_dn0", reread(8'hA1));
    rd(0, 9'd0, 0); chk_rd("wrap_dn1", reread(8'hA0));

    // Concurrent write (bank 0) and read (bank 1); swap lands mid-write
    idle(); wr_load = 1; wr_x = 9'd100; wr_en = 1; wr_data = 8'hB0;
    rd_load = 1; rd_x = 9'd511; rd_dir = 1; rd_en = 1; step();
    chk_rd("conc0", reread(8'hA0));
    idle(); wr_en = 1; wr_data = 8'hB1; rd_en = 1; swap = 1; step();
    chk_rd("conc1", reread(8'hA1));
    chk("swap3_wr_bank", 32'(wr_bank), 32'd1);
    wr(0, 9'd0, 8'hC2);
    do_swap();
    rd(1, 9'd102, 1); chk_rd("bank1_102", 8'hC2);
    do_swap();
    rd(1, 9'd100, 1); chk_rd("bank0_100", 8'hB0);
    rd(0, 9'd0, 1);   chk_rd("bank0_101", 8'hB1);

    // Clear-on-read pass: bank 1 addresses 0..3
    wr(1, 9'd0, 8'hD0);
    wr(0, 9'd0, 8'hD1);
    wr(0, 9'd0, 8'hD2);
    wr(0, 9'd0, 8'hD3);
    do_swap();
    rd(1, 9'd0, 1); chk_rd("p1_0", 8'hD0);
    rd(0, 9'd0, 1); chk_rd("p1_1", 8'hD1);
    rd(0, 9'd0, 1); chk_rd("p1_2", 8'hD2);
    rd(0, 9'd0, 1); chk_rd("p1_3", 8'hD3);
    do_swap();
    chk("b2b_swap_a", 32'(wr_bank), 32'd1);
    do_swap();
    chk("b2b_swap_b", 32'(wr_bank), 32'd0);
    rd(1, 9'd0, 1); chk_rd("p2_0", reread(8'hD0));
    rd(0, 9'd0, 1); chk_rd("p2_1", reread(8'hD1));
    rd(0, 9'd0, 1); chk_rd("p2_2", reread(8'hD2));
    rd(0, 9'd0, 1); chk_rd("p2_3", reread(8'hD3));

    // Asynchronous reset mid-line
    do_swap();
    idle(); rd_en = 1; rd_load = 1; rd_x = 9'd200; step();
    chk("pre_rst_valid", 32'(rd_valid), 32'd1);
    chk("pre_rst_bank", 32'(wr_bank), 32'd1);
    #2 RESETn = 0;
    #1;
    chk("async_rd_data", 32'(rd_data), 32'hFF);
    chk("async_rd_valid", 32'(rd_valid), 32'd0);
    chk("async_wr_bank", 32'(wr_bank), 32'd0);
    idle();
    @(negedge clk);
    RESETn = 1;
    rd(0, 9'd0, 1); chk_rd("post_rst_ra0", reread(8'hD0));
    wr(0, 9'd0, 8'hE0);
    do_swap();
    rd(1, 9'd0, 1); chk_rd("post_rst_wa0", 8'hE0);
    rd(1, 9'd11, 1); chk_rd("mem_kept", reread(8'h34));
    idle(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
